// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single memory-controller port between the instruction-fetch
// requester (IF) and the data-memory stage requester (DM). Each granted
// transfer holds mc_en high for MEM_LAT cycles. In the last of those cycles
// mc_rdata is captured. The matching ack then pulses for one cycle, and that
// ack cycle is also an IDLE cycle in which the next grant can be made.
//
// DM has priority over IF. A starvation counter forces an IF grant after
// STARVE_MAX consecutive DM grants that were made while IF was waiting.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous, active-low reset
//   if_req/if_addr        fetch read request (level) and address
//   if_data/if_ack        registered fetch data and its one-cycle valid pulse
//   if_stall              if_req & ~if_ack
//   dm_req/dm_we          data request (level); 1 = write, 0 = read
//   dm_addr/dm_wdata      data address and write data
//   dm_rdata/dm_ack       registered read data and completion pulse
//   dm_stall              dm_req & ~dm_ack
//   mc_en/mc_we           registered memory enable and write strobe
//   mc_addr/mc_wdata      registered memory address and write data
//   mc_rdata              memory read data, valid in the last mc_en cycle
module mem_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mc_en,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic [DATA_W-1:0] mc_rdata
);

  localparam int WAIT_W   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(MEM_LAT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_if;
  logic                grant_dm;
  logic                done;

  // Grant decision and transfer completion. Requests are looked at only in
  // IDLE, so request changes during a busy transfer have no effect.
  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // DM wins a tie unless IF has already been passed over STARVE_MAX times.
        if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
          grant_dm   = 1'b1;
          next_state = BUSY_DM;
        end else if (if_req) begin
          grant_if   = 1'b1;
          next_state = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (wait_cnt == WAIT_LAST) begin
          done       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory port, wait counter, starvation counter and returned data.
  // The acks default low every cycle so that each one is a single-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mc_en      <= 1'b0;
      mc_we      <= 1'b0;
      mc_addr    <= '0;
      mc_wdata   <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      if_data    <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (grant_dm) begin
        mc_en    <= 1'b1;
        mc_we    <= dm_we;
        mc_addr  <= dm_addr;
        mc_wdata <= dm_wdata;
        wait_cnt <= WAIT_INIT;
        // Only DM grants made while IF is waiting count toward starvation.
        if (!if_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end else if (grant_if) begin
        mc_en      <= 1'b1;
        mc_we      <= 1'b0;
        mc_addr    <= if_addr;
        mc_wdata   <= '0;
        wait_cnt   <= WAIT_INIT;
        starve_cnt <= '0;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
        if (done) begin
          mc_en    <= 1'b0;
          mc_we    <= 1'b0;
          mc_wdata <= '0;
          if (state == BUSY_IF) begin
            if_data <= mc_rdata;
            if_ack  <= 1'b1;
          end else begin
            // A write leaves the previously returned read data untouched.
            if (!mc_we) begin
              dm_rdata <= mc_rdata;
            end
            dm_ack <= 1'b1;
          end
        end
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule
